// File: rtl/inst_encode_issue.sv
// Encodes field-level requests into big-endian [0:31] words, queues them and issues them to fetch, with VNOP bubbles after branches.
// Latency: two edges from acceptance to out_valid. Backpressure: in_ready drops when the FIFO is full or a flush is asserted.
module inst_encode_issue #(
  parameter int DEPTH     = 4,
  parameter int NOP_SLOTS = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_kind,
  input  logic [0:4]               in_rd,
  input  logic [0:4]               in_ra,
  input  logic [0:4]               in_rb,
  input  logic [0:2]               in_ppp,
  input  logic [0:1]               in_ww,
  input  logic [0:5]               in_op,
  input  logic [0:15]              in_imm,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [0:31]              out_inst,
  output logic                     err_pulse,
  output logic [7:0]               err_cnt,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW     = $clog2(DEPTH);
  localparam int LW     = AW + 1;
  localparam int NOP_M1 = (NOP_SLOTS > 0) ? NOP_SLOTS - 1 : 0;
  localparam logic [2:0]  BUB_RELOAD = 3'(NOP_M1);
  localparam logic [0:31] VNOP_WORD  = 32'hF000_0000;

  logic [0:31]   mem_q [DEPTH];
  logic [0:31]   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          out_vld_q, out_vld_d;
  logic [0:31]   out_inst_q, out_inst_d;
  logic [2:0]    bub_cnt_q, bub_cnt_d;
  logic          err_pulse_q, err_pulse_d;
  logic [7:0]    err_cnt_q, err_cnt_d;

  logic [0:31] enc_word;
  logic        enc_bad;
  logic        full, accept, push, reject, pop, consume, load_en, out_is_branch;

  always_comb begin
    enc_word = '0;
    enc_bad  = 1'b0;
    case (in_kind)
      3'd0: begin
        enc_word = {6'b101010, in_rd, in_ra, in_rb, in_ppp, in_ww, in_op};
        // Decode ignores rB for these opcodes; a nonzero rB would be silently dropped.
        enc_bad  = (in_rb != 5'd0) &&
                   (in_op inside {6'b000100, 6'b000101, 6'b001101,
                                  6'b010000, 6'b010001, 6'b010010});
      end
      3'd1:    enc_word = {6'b100000, in_rd, 5'd0, in_imm};
      3'd2:    enc_word = {6'b100001, in_rd, 5'd0, in_imm};
      3'd3:    enc_word = {6'b100010, in_rd, 5'd0, in_imm};
      3'd4:    enc_word = {6'b100011, in_rd, 5'd0, in_imm};
      3'd5:    enc_word = VNOP_WORD;
      default: enc_bad  = 1'b1;
    endcase
  end

  assign full          = (level_q == LW'(DEPTH));
  assign in_ready      = !full && !flush;
  assign accept        = in_valid && in_ready;
  assign push          = accept && !enc_bad;
  assign reject        = accept && enc_bad;
  assign consume       = out_vld_q && out_ready;
  assign load_en       = !out_vld_q || consume;
  assign out_is_branch = (out_inst_q[0:4] == 5'b10001);

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    out_vld_d   = out_vld_q;
    out_inst_d  = out_inst_q;
    bub_cnt_d   = bub_cnt_q;
    pop         = 1'b0;
    err_pulse_d = reject;
    err_cnt_d   = err_cnt_q;
    if (reject && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end

    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      level_d   = '0;
      out_vld_d = 1'b0;
      bub_cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = enc_word;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (load_en) begin
        if (consume && out_is_branch && (NOP_SLOTS > 0)) begin
          out_inst_d = VNOP_WORD;
          bub_cnt_d  = BUB_RELOAD;
        end else if (bub_cnt_q != 3'd0) begin
          out_vld_d  = 1'b1;
          out_inst_d = VNOP_WORD;
          bub_cnt_d  = bub_cnt_q - 3'd1;
        end else if (level_q != '0) begin
          pop        = 1'b1;
          out_vld_d  = 1'b1;
          out_inst_d = mem_q[rd_ptr_q];
          rd_ptr_d   = rd_ptr_q + AW'(1);
        end else begin
          out_vld_d  = 1'b0;
        end
      end
      level_d = level_q + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_vld_q   <= 1'b0;
      out_inst_q  <= '0;
      bub_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_vld_q   <= out_vld_d;
      out_inst_q  <= out_inst_d;
      bub_cnt_q   <= bub_cnt_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid  = out_vld_q;
  assign out_inst   = out_inst_q;
  assign err_pulse  = err_pulse_q;
  assign err_cnt    = err_cnt_q;
  assign fifo_level = level_q;

endmodule
